// File: rtl/bounce_emulator.sv
// bounce_emulator: LFSR-timed contact-bounce generator driving a noisy copy of an ideal level.
// Optional single-cycle idle glitches are compiled in with BOUNCE_EMU_GLITCH_EN.
module bounce_emulator #(
    parameter int          CHATTER_LEN = 200,
    parameter int          HOLD_W      = 4,
    parameter int          CNT_W       = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clean,
    output logic             noisy,
    output logic             busy,
    output logic             settled,
    output logic [CNT_W-1:0] toggle_cnt
);
    localparam int               WIN_W    = $clog2(CHATTER_LEN);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(CHATTER_LEN - 1);
    localparam logic [15:0]      SEED_NZ  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    state_t            state_q, state_d;
    logic              clean_q, target_q, target_d, noisy_q, noisy_d, glitch;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;

    assign lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef BOUNCE_EMU_GLITCH_EN
    // noisy==target gate keeps back-to-back zero LFSR bytes from stretching a glitch
    assign glitch = (lfsr_q[7:0] == 8'h00) && (noisy_q == target_q);
`else
    assign glitch = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        noisy_d  = noisy_q;
        win_d    = win_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                noisy_d = target_q;
                if (!en) begin
                    noisy_d  = clean_q;
                    target_d = clean_q;
                end else if (clean_q != target_q) begin
                    target_d = clean_q;
                    noisy_d  = clean_q;
                    win_d    = WIN_LOAD;
                    hold_d   = lfsr_q[HOLD_W-1:0];
                    cnt_d    = CNT_W'(1);
                    state_d  = BOUNCE;
                end else if (glitch) begin
                    noisy_d = ~target_q;
                end
            end
            BOUNCE: begin
                win_d = win_q - 1'b1;
                if (!en) begin
                    noisy_d  = clean_q;
                    target_d = clean_q;
                    win_d    = win_q;
                    state_d  = IDLE;
                end else if (clean_q != target_q) begin
                    target_d = clean_q;
                    noisy_d  = clean_q;
                    win_d    = WIN_LOAD;
                    hold_d   = lfsr_q[HOLD_W-1:0];
                    cnt_d    = (clean_q != noisy_q) ? cnt_inc : cnt_q;
                end else if (win_q == '0) begin
                    noisy_d = target_q;
                    win_d   = win_q;
                    cnt_d   = (noisy_q != target_q) ? cnt_inc : cnt_q;
                    state_d = SETTLE;
                end else if (hold_q == '0) begin
                    noisy_d = ~noisy_q;
                    hold_d  = lfsr_q[HOLD_W-1:0];
                    cnt_d   = cnt_inc;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            clean_q  <= 1'b0;
            target_q <= 1'b0;
            noisy_q  <= 1'b0;
            lfsr_q   <= SEED_NZ;
            win_q    <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            clean_q  <= clean;
            target_q <= target_d;
            noisy_q  <= noisy_d;
            lfsr_q   <= lfsr_d;
            win_q    <= win_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
        end
    end

    assign noisy      = noisy_q;
    assign busy       = (state_q != IDLE);
    assign settled    = (state_q == SETTLE);
    assign toggle_cnt = cnt_q;
endmodule

// File: tb/tb_bounce_emulator.sv
// tb_bounce_emulator: directed scoreboard bench for bounce_emulator (default build and BOUNCE_EMU_GLITCH_EN build).
module tb_bounce_emulator;
    logic       clk = 1'b0, reset_n = 1'b0, en = 1'b1, clean = 1'b1;
    logic       noisy, busy, settled, n0, b0, s0, n1, b1, s1;
    logic [7:0] toggle_cnt, c0, c1;
    int         total = 0, bad = 0;

    typedef struct packed {logic n; logic [7:0] c;} samp_t;
    samp_t wave_q[$];
    logic  exp_q[$];

    bounce_emulator dut (.clk(clk), .reset_n(reset_n), .en(en), .clean(clean),
        .noisy(noisy), .busy(busy), .settled(settled), .toggle_cnt(toggle_cnt));
    bounce_emulator #(.SEED(16'h0000)) d0 (.clk(clk), .reset_n(reset_n), .en(en), .clean(clean),
        .noisy(n0), .busy(b0), .settled(s0), .toggle_cnt(c0));
    bounce_emulator #(.SEED(16'h0001)) d1 (.clk(clk), .reset_n(reset_n), .en(en), .clean(clean),
        .noisy(n1), .busy(b1), .settled(s1), .toggle_cnt(c1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 record waveform, 2 compare against recorded waveform
    task automatic press(input logic level, input bit rel, input int mode, input int exp_settle);
        int    trans, found;
        logic  prev;
        samp_t s;
        prev  = noisy;
        trans = 0;
        found = 0;
        if (rel) reset_n = 1'b1; else clean = level;
        for (int i = 1; i <= 400 && found == 0; i++) begin
            @(negedge clk);
            if (noisy !== prev) trans++;
            prev = noisy;
            if (i == 2) begin
                check("start_noisy", noisy, level);
                check("start_busy", busy, 1);
            end
            if (mode == 1) wave_q.push_back({noisy, toggle_cnt});
            if (mode == 2) begin
                s = (wave_q.size() > 0) ? wave_q.pop_front() : '0;
                check("det_noisy", noisy, s.n);
                check("det_cnt", toggle_cnt, s.c);
            end
            check("seed0_noisy", n0, n1);
            if (settled) begin
                found = i;
                check("settle_edge", i, exp_settle);
                check("settle_noisy", noisy, level);
            end
        end
        if (found == 0) check("settle_seen", 0, 1);
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_settled", settled, 0);
        check("idle_cnt", toggle_cnt, trans);
        check("cnt_parity", toggle_cnt[0], 1);
        check("seed0_cnt", c0, c1);
    endtask

    initial begin
        int   trans, first, pulses, g, longg, busy_seen, set_seen;
        logic prev;
        // reset with clean=1 held high
        repeat (2) @(negedge clk);
        check("rst_noisy", noisy, 0);
        check("rst_busy", busy, 0);
        check("rst_settled", settled, 0);
        check("rst_cnt", toggle_cnt, 0);
        press(1'b1, 1'b1, 1, 202);

        // bypass from a fresh reset: noisy is clean delayed two cycles
        reset_n = 1'b0; en = 1'b0; clean = 1'b0;
        @(negedge clk);
        check("byp_rst_cnt", toggle_cnt, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() >= 2) check("bypass_noisy", noisy, exp_q.pop_front());
            check("bypass_busy", busy, 0);
            check("bypass_cnt", toggle_cnt, 0);
            if (i % 5 == 0) clean = ~clean;
            exp_q.push_back(clean);
        end

        // same reset and stimulus as the first run must replay the same waveform
        reset_n = 1'b0; en = 1'b1; clean = 1'b1;
        repeat (2) @(negedge clk);
        press(1'b1, 1'b1, 2, 202);
        check("det_leftover", wave_q.size(), 0);

        // release event, then a press retargeted back to 0 at cycle 50
        press(1'b0, 1'b0, 0, 202);
        prev = noisy; trans = 0; first = 0; pulses = 0;
        clean = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            if (first == 0 && noisy !== prev) trans++;
            prev = noisy;
            if (i == 2) check("rt_press_noisy", noisy, 1);
            if (i == 52) begin
                check("rt_noisy", noisy, 0);
                check("rt_busy", busy, 1);
            end
            if (i == 252) check("rt_final", noisy, 0);
            if (settled) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == 50) clean = 1'b0;
        end
        check("rt_settle_edge", first, 252);
        check("rt_pulses", pulses, 1);
        check("rt_cnt", toggle_cnt, trans);
        check("rt_parity", toggle_cnt[0], 0);

        // idle stability (glitch pulses when the feature is built in)
        prev = noisy; g = 0; longg = 0; busy_seen = 0; set_seen = 0;
`ifdef BOUNCE_EMU_GLITCH_EN
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (noisy !== clean && prev === clean) g++;
            if (noisy !== clean && prev !== clean) longg++;
            if (busy) busy_seen++;
            if (settled) set_seen++;
            prev = noisy;
        end
        check("glitch_single", longg, 0);
        check("glitch_rate_ok", (g >= 55 && g <= 100), 1);
`else
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (noisy !== clean) g++;
            if (busy) busy_seen++;
            if (settled) set_seen++;
        end
        check("idle_stable", g, 0);
`endif
        check("idle_busy_seen", busy_seen, 0);
        check("idle_settled_seen", set_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bounce_emulator.md
Name: bounce_emulator

Overview:
- Synthesizable contact-bounce generator: the transmitter side of the noisy-button interface that the debouncer receives.
- Takes an ideal level `clean` (from a testbench, a slide switch or a CPU register). Drives `noisy` with a deterministic, LFSR-timed chatter burst after every `clean` change, then settles to the new level.
- Used for on-board demos and self-test of the debounce path without a physical bouncing switch.

Parameters:
- CHATTER_LEN, 200, length of the bounce window in clk cycles (>=2).
- HOLD_W, 4, chatter segment hold time is 1..2^HOLD_W cycles.
- CNT_W, 8, width of toggle_cnt.
- SEED, 16'hACE1, LFSR reset value; a zero value is replaced by 16'h0001.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  1 = emulate bounce; 0 = bypass (noisy follows clean)
- clean  in  1  ideal button level
- noisy  out  1  bouncy output toward the debouncer
- busy  out  1  high while in BOUNCE or SETTLE
- settled  out  1  one-cycle pulse when a bounce event completes
- toggle_cnt  out  CNT_W  number of noisy transitions in the current/last event, saturating

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: noisy=0, busy=0, settled=0, toggle_cnt=0, state=IDLE, internal clean_q=0, target=0, lfsr=SEED.
- clean is registered into clean_q every cycle (1 cycle latency). All outputs are registered or decoded from state.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle in every state, never zero.
- State IDLE:
  - noisy holds target.
  - If en=1 and clean_q!=target: target<=clean_q, noisy<=clean_q, win<=CHATTER_LEN-1, hold<=lfsr[HOLD_W-1:0], toggle_cnt<=1, go BOUNCE.
- State BOUNCE, priority order:
  - (a) en=0: noisy<=clean_q, target<=clean_q, go IDLE, no settled pulse.
  - (b) clean_q!=target (retarget): target<=clean_q, noisy<=clean_q, win<=CHATTER_LEN-1, reload hold, toggle_cnt +1 if noisy changes.
  - (c) win==0: noisy<=target, toggle_cnt +1 if noisy!=target, go SETTLE.
  - (d) hold==0: noisy<=~noisy, hold<=lfsr[HOLD_W-1:0], toggle_cnt +1.
  - (e) otherwise: hold-1.
  - win decrements every BOUNCE cycle except (a)/(b)/(c).
- State SETTLE:
  - settled=1 and noisy=target for exactly one cycle, then go IDLE unconditionally.
  - A clean change seen in SETTLE is picked up by IDLE on the next cycle.
- busy = (state!=IDLE). settled = (state==SETTLE).
- toggle_cnt saturates at 2^CNT_W-1 and holds its value until the next event starts.
- Bypass: with en=0 in IDLE, noisy<=clean_q and target<=clean_q every cycle (2-cycle latency clean->noisy).
- Reset asserted mid-event returns everything to reset values immediately. No settled pulse is emitted.

Optional Feature:
- Macro BOUNCE_EMU_GLITCH_EN.
- Defined: in IDLE with en=1 and no level change pending, when lfsr[7:0]==8'h00, noisy is inverted for exactly one cycle (glitch), then restored.
  - Glitches do not change target, busy, settled or toggle_cnt.
  - This exercises the debouncer's short-pulse rejection.
- Undefined: noisy is perfectly stable in IDLE; glitch logic is absent.

Test Plan:
- Reset: hold reset_n=0 with clean=1 -> noisy=0, busy=0, settled=0, toggle_cnt=0; after release, IDLE sees clean_q=1 and starts a BOUNCE event.
- Single press, CHATTER_LEN=200, en=1: clean 0->1 before edge 1 -> noisy=1 after edge 2, busy=1; settled high for one cycle after edge 202; noisy=1 stable thereafter; toggle_cnt odd and >=1.
- Release during bounce: clean 1->0 at cycle 50 of a press event -> noisy=0 two edges later, window restarts; settled occurs 200 cycles after the retarget, final noisy=0.
- Bypass: en=0, toggle clean every 5 cycles -> noisy equals clean delayed 2 cycles; busy stays 0; toggle_cnt unchanged.
- Determinism: two runs with SEED=16'hACE1 and the same stimulus -> identical noisy waveform and toggle_cnt; SEED=0 behaves as SEED=1 (no lock-up).
- Glitch (BOUNCE_EMU_GLITCH_EN defined): idle 100000 cycles with en=1 -> only single-cycle noisy pulses, count ~390 ±10%, target unchanged, settled never asserted.
